// File: rtl/mux_serial_nl_pkg.sv
// mux_serial_pkg: shared definitions for the mux_serial_nl serialising mux.
//   MODE_FIXED / MODE_COMPACT : per-frame slot mode carried on `selector`
//   state_e                   : frame FSM states (IDLE, EMIT)
//   idx_width()               : lane-index width for a given lane count
package mux_serial_pkg;

    localparam logic MODE_FIXED   = 1'b0;
    localparam logic MODE_COMPACT = 1'b1;

    typedef enum logic {
        IDLE,
        EMIT
    } state_e;

    function automatic int unsigned idx_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/mux_serial_nl_lane_pick.sv
// lane_pick: purely combinational search for the lowest set mask bit at or
// above a pointer.
//   mask : per-lane valid mask
//   ptr  : search start; one bit wider than a lane index so that LANES
//          itself (past the last lane) can be expressed
//   idx  : lowest set lane >= ptr (0 when none)
//   none : no set lane at or above ptr
module lane_pick
    import mux_serial_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [LANES-1:0] mask,
    input  logic [IDX_W:0]   ptr,
    output logic [IDX_W-1:0] idx,
    output logic             none
);

    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (none && mask[i] && (i >= 32'(ptr))) begin
                idx  = IDX_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_serial_nl.sv
// mux_serial_nl: LANES-to-1 serialising multiplexer, one word per clk_4f.
// A frame of LANES words plus valid mask is captured in one cycle and
// emitted one slot per cycle, either in fixed-slot mode (every lane gets a
// slot) or compact mode (only valid lanes get a slot).
//   clk_4f, reset      : clock, synchronous active-high reset
//   Entrada            : frame data, lane i at [i*WIDTH +: WIDTH]
//   validEntrada       : per-lane valid mask
//   frame_valid        : frame presented this cycle
//   selector           : 0 = fixed-slot, 1 = compact (captured per frame)
//   in_ready           : frame accepted this cycle if frame_valid
//   Salida/validSalida : serial word and its valid flag
//   lane_id            : source lane of the current slot
//   sof                : first slot of a frame
//   parity             : ^Salida in valid slots (only with MUX_SERIAL_PARITY_EN)
module mux_serial_nl
    import mux_serial_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = idx_width(LANES)
) (
    input  logic                   clk_4f,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] Entrada,
    input  logic [LANES-1:0]       validEntrada,
    input  logic                   frame_valid,
    input  logic                   selector,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       Salida,
    output logic                   validSalida,
    output logic [IDX_W-1:0]       lane_id,
    output logic                   sof
`ifdef MUX_SERIAL_PARITY_EN
    ,
    output logic                   parity
`endif
);

    state_e                        state_q, state_d;
    logic [LANES-1:0][WIDTH-1:0]   data_q, data_d;
    logic [LANES-1:0]              mask_q, mask_d;
    logic                          mode_q, mode_d;
    logic [IDX_W-1:0]              ptr_q, ptr_d;
    logic                          first_q, first_d;
    logic [WIDTH-1:0]              salida_q, salida_d;
    logic                          valid_q, valid_d;
    logic [IDX_W-1:0]              lane_id_q, lane_id_d;
    logic                          sof_q, sof_d;
`ifdef MUX_SERIAL_PARITY_EN
    logic                          parity_q, parity_d;
`endif

    logic [IDX_W:0]   ptr_inc;
    logic [IDX_W-1:0] next_idx, first_idx;
    logic             next_none, first_none;
    logic             last_slot, accept, has_slot;

    assign ptr_inc = {1'b0, ptr_q} + {{IDX_W{1'b0}}, 1'b1};

    // Next valid lane after the current slot (compact advance / last test).
    lane_pick #(.LANES(LANES), .IDX_W(IDX_W)) u_pick_next (
        .mask (mask_q),
        .ptr  (ptr_inc),
        .idx  (next_idx),
        .none (next_none)
    );

    // First valid lane of the incoming frame (compact start / empty test).
    lane_pick #(.LANES(LANES), .IDX_W(IDX_W)) u_pick_first (
        .mask (validEntrada),
        .ptr  ('0),
        .idx  (first_idx),
        .none (first_none)
    );

    // ptr_q names the slot being prepared; the output registers show it one
    // cycle later. Readiness is raised while the last slot is being prepared
    // so that a new frame's first slot follows it with no bubble.
    assign last_slot = (state_q == EMIT) &&
                       ((mode_q == MODE_FIXED) ? (ptr_q == IDX_W'(LANES - 1))
                                               : next_none);
    assign in_ready  = !reset && ((state_q == IDLE) || last_slot);
    assign accept    = frame_valid && in_ready;
    assign has_slot  = (selector == MODE_FIXED) || !first_none;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        mask_d    = mask_q;
        mode_d    = mode_q;
        ptr_d     = ptr_q;
        first_d   = first_q;
        salida_d  = '0;
        valid_d   = 1'b0;
        lane_id_d = '0;
        sof_d     = 1'b0;

        if (state_q == EMIT) begin
            lane_id_d = ptr_q;
            sof_d     = first_q;
            valid_d   = (mode_q == MODE_COMPACT) ? 1'b1 : mask_q[ptr_q];
            salida_d  = valid_d ? data_q[ptr_q] : '0;
            first_d   = 1'b0;
            if (last_slot) begin
                state_d = IDLE;
            end else begin
                ptr_d = (mode_q == MODE_FIXED) ? ptr_inc[IDX_W-1:0] : next_idx;
            end
        end

        if (accept) begin
            data_d  = Entrada;
            mask_d  = validEntrada;
            mode_d  = selector;
            first_d = 1'b1;
            ptr_d   = (selector == MODE_COMPACT) ? first_idx : '0;
            state_d = has_slot ? EMIT : IDLE;
        end
    end

`ifdef MUX_SERIAL_PARITY_EN
    assign parity_d = valid_d & (^salida_d);
`endif

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            mask_q    <= '0;
            mode_q    <= MODE_FIXED;
            ptr_q     <= '0;
            first_q   <= 1'b0;
            salida_q  <= '0;
            valid_q   <= 1'b0;
            lane_id_q <= '0;
            sof_q     <= 1'b0;
`ifdef MUX_SERIAL_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            ptr_q     <= ptr_d;
            first_q   <= first_d;
            salida_q  <= salida_d;
            valid_q   <= valid_d;
            lane_id_q <= lane_id_d;
            sof_q     <= sof_d;
`ifdef MUX_SERIAL_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign Salida      = salida_q;
    assign validSalida = valid_q;
    assign lane_id     = lane_id_q;
    assign sof         = sof_q;
`ifdef MUX_SERIAL_PARITY_EN
    assign parity      = parity_q;
`endif

endmodule

// File: tb/tb_mux_serial_nl.sv
// tb_mux_serial_nl: directed and random stimulus for mux_serial_nl
// (LANES=4, WIDTH=8). The reference model expands each accepted frame into
// its list of output slots and replays them one per cycle.
module tb_mux_serial_nl;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic [1:0] id;
        logic       sof;
    } slot_t;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [31:0] Entrada;
    logic [3:0]  validEntrada;
    logic        frame_valid;
    logic        selector;
    logic        in_ready;
    logic [7:0]  Salida;
    logic        validSalida;
    logic [1:0]  lane_id;
    logic        sof;
`ifdef MUX_SERIAL_PARITY_EN
    logic        parity;
`endif

    int    checks = 0;
    int    errors = 0;
    slot_t q[$];
    slot_t expo;
    logic  acc;

    always #5 clk_4f = ~clk_4f;

    mux_serial_nl #(.LANES(4), .WIDTH(8)) dut (
        .clk_4f       (clk_4f),
        .reset        (reset),
        .Entrada      (Entrada),
        .validEntrada (validEntrada),
        .frame_valid  (frame_valid),
        .selector     (selector),
        .in_ready     (in_ready),
        .Salida       (Salida),
        .validSalida  (validSalida),
        .lane_id      (lane_id),
        .sof          (sof)
`ifdef MUX_SERIAL_PARITY_EN
        ,
        .parity       (parity)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Slot list of one frame, straight from the mode rules.
    task automatic push_frame(input logic [31:0] d, input logic [3:0] m, input logic s);
        logic       first;
        slot_t      e;
        logic [7:0] w;
        first = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = d[i*8 +: 8];
            if (!s) begin
                e.d   = m[i] ? w : 8'h00;
                e.v   = m[i];
                e.id  = 2'(i);
                e.sof = (i == 0);
                q.push_back(e);
            end else if (m[i]) begin
                e.d   = w;
                e.v   = 1'b1;
                e.id  = 2'(i);
                e.sof = first;
                first = 1'b0;
                q.push_back(e);
            end
        end
    endtask

    // One clock: drive, check readiness, advance model, check outputs.
    task automatic cycle(input logic rst, input logic fv, input logic [31:0] d,
                         input logic [3:0] m, input logic s);
        logic exp_rdy;
        @(negedge clk_4f);
        reset        = rst;
        frame_valid  = fv;
        Entrada      = d;
        validEntrada = m;
        selector     = s;
        #1;
        // Ready when nothing is pending or only the final slot remains.
        exp_rdy = !rst && (q.size() <= 1);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = fv && exp_rdy;
        @(posedge clk_4f);
        if (rst) begin
            q.delete();
            expo = '0;
        end else begin
            if (q.size() > 0) expo = q.pop_front();
            else expo = '0;
            if (acc) push_frame(d, m, s);
        end
        #1;
        check("Salida", 32'(Salida), 32'(expo.d));
        check("validSalida", 32'(validSalida), 32'(expo.v));
        check("lane_id", 32'(lane_id), 32'(expo.id));
        check("sof", 32'(sof), 32'(expo.sof));
`ifdef MUX_SERIAL_PARITY_EN
        check("parity", 32'(parity), 32'(expo.v & (^expo.d)));
`endif
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] m, input logic s);
        int n;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 40) begin
            cycle(1'b0, 1'b1, d, m, s);
            n++;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL send_timeout: got not-accepted expected accepted");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        logic        pend;
        logic        r;
        logic [31:0] pd;
        logic [3:0]  pm;
        logic        ps;

        reset        = 1'b1;
        frame_valid  = 1'b0;
        Entrada      = '0;
        validEntrada = '0;
        selector     = 1'b0;

        // Reset, with a frame offered that must be ignored.
        cycle(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0);
        idle(1);

        // Fixed, full mask.
        send(32'h44332211, 4'hF, 1'b0);
        idle(6);
        // Fixed, partial mask.
        send(32'h44332211, 4'b0101, 1'b0);
        idle(6);
        // Compact, partial mask.
        send(32'h44332211, 4'b1010, 1'b1);
        idle(4);
        // Back-to-back, fixed full.
        send(32'h44332211, 4'hF, 1'b0);
        send(32'h88776655, 4'hF, 1'b0);
        send(32'hCCBBAA99, 4'hF, 1'b0);
        idle(6);
        // Compact empty mask, then a frame right behind it.
        send(32'hDEADBEEF, 4'b0000, 1'b1);
        send(32'h44332211, 4'b0100, 1'b1);
        idle(3);
        // Compact single lane at top, back-to-back with compact.
        send(32'hA1B2C3D4, 4'b1000, 1'b1);
        send(32'hA1B2C3D4, 4'b1001, 1'b1);
        idle(4);
        // Reset on the second slot.
        send(32'h44332211, 4'hF, 1'b0);
        idle(2);
        cycle(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        idle(5);

        // Random traffic, upstream holds each frame until accepted.
        pend = 1'b0;
        pd   = '0;
        pm   = '0;
        ps   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 39) == 0);
            if (!pend) begin
                pd   = $urandom;
                pm   = 4'($urandom);
                ps   = 1'($urandom);
                pend = ($urandom_range(0, 3) != 0);
            end
            cycle(r, pend, pd, pm, ps);
            if (acc) pend = 1'b0;
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_serial_nl.md
# mux_serial_nl

Parametrised N-lane to 1-lane serialising multiplexer, the single-clock successor of the fixed 4:1 byte mux chain. A complete frame of `LANES` words, with a per-lane valid mask, is captured in one cycle and emitted one word per cycle on a single output lane. Per frame, the block runs in one of two modes: fixed-slot, where every lane occupies a slot, or compact, where invalid lanes are skipped. It sits between the lane-parallel datapath and the serial link encoder.

## Interface
- `LANES`, 4, number of input lanes; power of two, 2..16
- `WIDTH`, 8, bits per word
- `IDX_W`, $clog2(LANES), lane-index width (derived; do not override)

- `clk_4f`  in  1  single clock at output word rate; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `Entrada`  in  LANES*WIDTH  frame data; lane i at bits [i*WIDTH +: WIDTH]
- `validEntrada`  in  LANES  per-lane valid mask of the presented frame
- `frame_valid`  in  1  frame presented this cycle
- `selector`  in  1  mode for the presented frame: 0 = fixed-slot, 1 = compact
- `in_ready`  out  1  block accepts a frame this cycle
- `Salida`  out  WIDTH  serial output word
- `validSalida`  out  1  `Salida` carries a valid word
- `lane_id`  out  IDX_W  source lane of the current output slot
- `sof`  out  1  first output slot of a frame

## Operation
- **Accept rule.** A frame is accepted on a rising edge where `frame_valid && in_ready`. On acceptance the block captures `Entrada`, `validEntrada` and `selector` into the frame register. `selector` therefore applies per frame; changes mid-frame have no effect.
- **States.**
  - IDLE: no frame held.
  - EMIT: frame held, slots pending.
  - IDLE → EMIT on acceptance of a frame that has at least one slot.
  - EMIT → EMIT on the last slot when a new frame is accepted on the same edge.
  - EMIT → IDLE on the last slot with no acceptance.
- **`in_ready`** = (state == IDLE) || (last slot of current frame being emitted) || `reset` deasserted-but-not-yet-run. In the first cycle after reset, `in_ready` = 1.
- **Fixed-slot mode (`selector`=0).**
  - Exactly `LANES` slots per frame, lane 0 first, ascending.
  - Slot i: `lane_id`=i, `validSalida`=mask[i], `Salida`=mask[i] ? data[i] : 0.
- **Compact mode (`selector`=1).**
  - One slot per set mask bit, ascending lane order. `validSalida`=1 in every slot.
  - A frame with an all-zero mask is accepted and dropped: no slots, state stays IDLE, `in_ready` stays 1.
- **Between frames** (IDLE): `validSalida`=0, `Salida`=0, `sof`=0, `lane_id`=0.
- **`sof`** = 1 only in the first slot of each frame, whether or not that slot is valid.
- **`frame_valid` while `in_ready`=0** is ignored. Upstream must hold the frame until it is accepted.

## Timing
- All outputs are registered.
- **Reset.** `Salida`=0, `validSalida`=0, `lane_id`=0, `sof`=0, state IDLE, frame register cleared; `in_ready`=0 while `reset`=1.
- **Latency.** A frame accepted at edge k has its first slot on the outputs after edge k+1.
- **Back-to-back frames.** Accepting on the last-slot edge gives zero bubbles, so sustained throughput is 1 word/cycle.
- **Frame length.** Fixed mode: exactly `LANES` cycles. Compact mode: popcount(mask) cycles.
- **Reset mid-frame.** The frame in progress is discarded and never resumed; outputs return to reset values on the next edge.
- **Single-lane compact frame.** That frame's first slot is also its last slot: `sof`=1 and `in_ready`=1 in the same cycle.

## Configuration
- `MUX_SERIAL_PARITY_EN`
  - Defined: adds output `parity` (1 bit, registered) = ^`Salida` in valid slots and 0 otherwise; reset value 0.
  - Undefined: the port and its logic are absent, and the port list is exactly as above.

## Structure
- Package `mux_serial_pkg` holds:
  - constants `MODE_FIXED`=1'b0 and `MODE_COMPACT`=1'b1;
  - the state enum (IDLE, EMIT);
  - a function for index width.
- Sub-module `lane_pick`, purely combinational: given the mask and the current pointer, returns the next set lane at or above the pointer, plus a "none left" flag. It is used for compact-mode advance and for last-slot detection.
- Top level holds the frame register, slot pointer, FSM and output registers.

## Test plan
All scenarios use `LANES`=4, `WIDTH`=8.
- **Fixed mode, full mask.** Frame {0x44,0x33,0x22,0x11} (lane3..0), mask 4'hF, `selector`=0 → `Salida` 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting one cycle after accept; `sof` on the 0x11 slot; `lane_id` 0..3.
- **Fixed mode, partial mask.** Same data, mask 4'b0101 → slots 0x11 (valid), 0x00 (invalid), 0x33 (valid), 0x00 (invalid).
- **Compact mode, partial mask.** Same data, mask 4'b1010 → 2 slots: 0x22 (`lane_id`=1, `sof`=1), then 0x44 (`lane_id`=3); `in_ready`=1 on the 0x44 cycle.
- **Back-to-back frames.** Three frames presented back-to-back with `frame_valid` held → 12 consecutive valid slots (fixed, full mask), no bubbles; `in_ready` low except IDLE and last-slot cycles.
- **Compact, empty mask.** Mask 4'b0000 → no `validSalida` at all; `in_ready` stays 1; the next frame's first slot appears one cycle after its own acceptance.
- **Reset mid-frame.** `reset` asserted on the 2nd slot → the next edge shows all outputs 0; after release, no residual slots, and `in_ready`=1 one cycle after release.
